cache_mem_arbiter: RTL and testbench

- Arbitrates one shared main-memory port between the OTTER instruction-cache refill path (I side) and the data-cache refill/write-back path (D side).
- Each grant runs a full cache-line burst of WORDS_PER_LINE words, one word per MEM_ACK.
- Sits between the two caches and main memory inside OTTER_MCU.
- Arbitration is round-robin, so a stalled fetch and a stalled load/store can never starve each other.

---
 rtl/cache_mem_arbiter.sv | 115 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache refills
// and D-cache refills/write-backs, one full line burst per grant.
module cache_mem_arbiter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              I_REQ,
  input  logic [ADDR_W-1:0]                 I_ADDR,
  output logic [DATA_W-1:0]                 I_RDATA,
  output logic                              I_VALID,
  output logic                              I_DONE,
  input  logic                              D_REQ,
  input  logic                              D_WE,
  input  logic [ADDR_W-1:0]                 D_ADDR,
  input  logic [DATA_W-1:0]                 D_WDATA,
  output logic [DATA_W-1:0]                 D_RDATA,
  output logic                              D_VALID,
  output logic                              D_DONE,
  output logic [$clog2(WORDS_PER_LINE)-1:0] WORD_IDX,
  output logic [ADDR_W-1:0]                 MEM_ADDR,
  output logic                              MEM_RE,
  output logic                              MEM_WE,
  output logic [DATA_W-1:0]                 MEM_WDATA,
  input  logic [DATA_W-1:0]                 MEM_RDATA,
  input  logic                              MEM_ACK
);

  localparam int BW = $clog2(WORDS_PER_LINE);
  localparam int OW = $clog2(WORDS_PER_LINE * 4);

  typedef enum logic [1:0] {
    IDLE,
    BURST_I,
    BURST_D,
    DONE
  } state_t;

  state_t            state;
  logic              own_d;
  logic              last_d;
  logic [BW-1:0]     beat;
  logic [ADDR_W-1:0] base;
  logic              re_q;
  logic              we_q;

  logic              pick_d;
  logic              last_beat;
  logic              ack;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] line;

  // D wins a tie unless it was granted last.
  assign pick_d    = D_REQ & (~I_REQ | ~last_d);
  assign req_addr  = pick_d ? D_ADDR : I_ADDR;
  assign line      = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign last_beat = beat == BW'(WORDS_PER_LINE - 1);
  assign ack       = MEM_ACK & (state == BURST_I || state == BURST_D);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      own_d  <= 1'b0;
      last_d <= 1'b0;
      beat   <= '0;
      base   <= '0;
      re_q   <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (I_REQ | D_REQ) begin
            state  <= pick_d ? BURST_D : BURST_I;
            own_d  <= pick_d;
            last_d <= pick_d;
            base   <= line;
            beat   <= '0;
            re_q   <= ~(pick_d & D_WE);
            we_q   <= pick_d & D_WE;
          end
        end
        BURST_I, BURST_D: begin
          if (MEM_ACK) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              state <= DONE;
              re_q  <= 1'b0;
              we_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          beat  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MEM_ADDR  = base | (ADDR_W'(beat) << 2);
  assign WORD_IDX  = beat;
  assign MEM_RE    = re_q;
  assign MEM_WE    = we_q;
  assign MEM_WDATA = D_WDATA;
  assign I_RDATA   = MEM_RDATA;
  assign D_RDATA   = MEM_RDATA;
  assign I_VALID   = ack & ~own_d;
  assign D_VALID   = ack & own_d;
  assign I_DONE    = (state == DONE) & ~own_d;
  assign D_DONE    = (state == DONE) & own_d;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_done;
  logic [2:0]  word_idx;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr;
  assign d_wdata   = 32'hA0 + 32'(word_idx);

  cache_mem_arbiter #(
    .WORDS_PER_LINE(8),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .CLK(clk),
    .RESET(reset),
    .I_REQ(i_req),
    .I_ADDR(i_addr),
    .I_RDATA(i_rdata),
    .I_VALID(i_valid),
    .I_DONE(i_done),
    .D_REQ(d_req),
    .D_WE(d_we),
    .D_ADDR(d_addr),
    .D_WDATA(d_wdata),
    .D_RDATA(d_rdata),
    .D_VALID(d_valid),
    .D_DONE(d_done),
    .WORD_IDX(word_idx),
    .MEM_ADDR(mem_addr),
    .MEM_RE(mem_re),
    .MEM_WE(mem_we),
    .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata),
    .MEM_ACK(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " re"}, 32'(mem_re), 0);
    chk({tag, " we"}, 32'(mem_we), 0);
    chk({tag, " iv"}, 32'(i_valid), 0);
    chk({tag, " dv"}, 32'(d_valid), 0);
    chk({tag, " idx"}, 32'(word_idx), 0);
  endtask

  // Called just after the grant edge of a zero-wait read burst.
  task automatic burst(input string tag, input logic d,
                       input logic [31:0] base, input int drop);
    for (int k = 0; k < 8; k++) begin
      if (k == drop) begin
        if (d) d_req = 1'b0;
        else   i_req = 1'b0;
      end
      #1;
      chk({tag, " addr"}, mem_addr, base + 32'(4 * k));
      chk({tag, " idx"}, 32'(word_idx), 32'(k));
      chk({tag, " re"}, 32'(mem_re), 1);
      chk({tag, " we"}, 32'(mem_we), 0);
      chk({tag, " iv"}, 32'(i_valid), 32'(!d));
      chk({tag, " dv"}, 32'(d_valid), 32'(d));
      chk({tag, " rd"}, d ? d_rdata : i_rdata, base + 32'(4 * k));
      step();
    end
    chk({tag, " idone"}, 32'(i_done), 32'(!d));
    chk({tag, " ddone"}, 32'(d_done), 32'(d));
    chk({tag, " re@done"}, 32'(mem_re), 0);
    chk({tag, " iv@done"}, 32'(i_valid), 0);
    chk({tag, " dv@done"}, 32'(d_valid), 0);
    step();
    chk({tag, " idone2"}, 32'(i_done), 0);
    chk({tag, " ddone2"}, 32'(d_done), 0);
    chk({tag, " re@idle"}, 32'(mem_re), 0);
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; mem_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    chk_idle("rst");
    chk("rst addr", mem_addr, 0);
    chk("rst idone", 32'(i_done), 0);
    chk("rst ddone", 32'(d_done), 0);

    // single I refill, zero-wait
    i_req = 1'b1; i_addr = 32'h0000_1014; mem_ack = 1'b1;
    step();
    burst("i1", 1'b0, 32'h0000_1000, 8);
    mem_ack = 1'b0;

    // tie out of reset: D first, then I after one IDLE cycle
    reset = 1'b1; step(); reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_addr = 32'h0000_2004; d_we = 1'b0;
    mem_ack = 1'b1;
    step();
    burst("tieD", 1'b1, 32'h0000_2000, 0);
    chk("tieI wait", 32'(i_valid), 0);
    step();
    burst("tieI", 1'b0, 32'h0000_1000, 0);

    // D alone, then tie again: I must win
    d_req = 1'b1; d_addr = 32'h0000_2000;
    step();
    burst("soloD", 1'b1, 32'h0000_2000, 0);
    i_req = 1'b1; d_req = 1'b1;
    step();
    burst("tie2I", 1'b0, 32'h0000_1000, 0);
    step();
    burst("tie2D", 1'b1, 32'h0000_2000, 0);

    // write-back, ACK every third cycle
    mem_ack = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3000;
    step();
    d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) begin
        mem_ack = (c == 2);
        #1;
        chk("wb we", 32'(mem_we), 1);
        chk("wb re", 32'(mem_re), 0);
        chk("wb addr", mem_addr, 32'h0000_3000 + 32'(4 * k));
        chk("wb wdata", mem_wdata, 32'hA0 + 32'(k));
        chk("wb dv", 32'(d_valid), 32'(c == 2));
        chk("wb iv", 32'(i_valid), 0);
        step();
      end
    end
    mem_ack = 1'b0;
    #1;
    chk("wb ddone", 32'(d_done), 1);
    chk("wb we@done", 32'(mem_we), 0);
    step();

    // owner drops request after beat 2
    mem_ack = 1'b1;
    i_req = 1'b1; i_addr = 32'h0000_4008;
    step();
    burst("drop", 1'b0, 32'h0000_4000, 3);

    // line at the top of the address space
    i_req = 1'b1; i_addr = 32'hFFFF_FFF4;
    step();
    burst("wrap", 1'b0, 32'hFFFF_FFE0, 0);

    // reset during beat 4 of a D refill
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5010;
    step();
    for (int k = 0; k < 4; k++) step();
    #1;
    chk("rstm idx4", 32'(word_idx), 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk_idle("rstm");
    chk("rstm ddone", 32'(d_done), 0);
    chk("rstm addr", mem_addr, 0);
    step();
    burst("rstm again", 1'b1, 32'h0000_5000, 0);

    // spurious ACKs while idle
    for (int k = 0; k < 4; k++) begin
      mem_ack = k[0];
      step();
      chk_idle("spur");
      chk("spur idone", 32'(i_done), 0);
      chk("spur ddone", 32'(d_done), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
